// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one operation in flight, HI/LO results presented with a one-cycle done pulse.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero,
  output logic [2:0]       dbg_state
);

  // Handshake: start is sampled only while idle; busy is high from the cycle after
  // accept until done is pulsed; done marks hi_out/lo_out/div_zero as new for one cycle.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   CNT_LAST = WIDTH'(WIDTH - 1);

  state_t             r_state;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_sign_res;
  logic               r_sign_rem;
  logic               r_dz;

  logic               w_is_div;
  logic               w_is_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_is_div    = r_op[1];
  assign w_is_signed = ~r_op[0];
  assign w_neg_a     = w_is_signed & r_a[WIDTH-1];
  assign w_neg_b     = w_is_signed & r_b[WIDTH-1];
  assign w_abs_a     = w_neg_a ? (~r_a + ONE_W) : r_a;
  assign w_abs_b     = w_neg_b ? (~r_b + ONE_W) : r_b;
  assign w_b_zero    = (r_b == '0);

  // Multiply: multiplier sits in the low half of r_acc and shifts out LSB first,
  // r_opnd holds the multiplicand added into the high half.
  assign w_addend  = r_acc[0] ? r_opnd : '0;
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

  // Divide: dividend shifts out of the low half MSB first while quotient bits
  // shift in; r_opnd holds the divisor.
  assign w_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_opnd};
  assign w_fits  = ~w_diff[WIDTH];

  // Sign flags are only ever set for signed ops, so unsigned results pass through.
  assign w_prod_fix = r_sign_res ? (~r_acc + ONE_2W) : r_acc;
  assign w_quo_fix  = r_sign_res ? (~r_acc[WIDTH-1:0] + ONE_W) : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_sign_rem ? (~r_rem + ONE_W) : r_rem;

  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_opnd     <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_sign_res <= 1'b0;
      r_sign_rem <= 1'b0;
      r_dz       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi_out     <= '0;
      lo_out     <= '0;
      div_zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= src_a;
            r_b     <= src_b;
            busy    <= 1'b1;
            r_state <= S_PREP;
          end
        end

        S_PREP: begin
          if (cancel) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_sign_res <= w_neg_a ^ w_neg_b;
            r_sign_rem <= w_neg_a;
            if (w_is_div && w_b_zero) begin
              r_dz    <= 1'b1;
              r_acc   <= {r_a, {WIDTH{1'b1}}};
              r_state <= S_DONE;
            end else begin
              r_dz  <= 1'b0;
              r_cnt <= '0;
              r_rem <= '0;
              if (w_is_div) begin
                r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                r_opnd <= w_abs_b;
              end else begin
                r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                r_opnd <= w_abs_a;
              end
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (cancel) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (w_is_div) begin
              r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_fits};
              r_rem            <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            end else begin
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + ONE_W;
            if (r_cnt == CNT_LAST) begin
              r_state <= S_FIX;
            end
          end
        end

        S_FIX: begin
          if (cancel) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (w_is_div) begin
              r_acc <= {w_rem_fix, w_quo_fix};
            end else begin
              r_acc <= w_prod_fix;
            end
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          done     <= 1'b1;
          hi_out   <= r_acc[2*WIDTH-1:WIDTH];
          lo_out   <= r_acc[WIDTH-1:0];
          div_zero <= r_dz;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit and an 8-bit instance driven by directed steps,
// results checked through expected-value queues filled from an arithmetic model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        st32, cn32;
  logic [1:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic [2:0]  state32;

  logic        st8, cn8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;
  logic [2:0]  state8;

  int checks   = 0;
  int failures = 0;

  logic [64:0] exp32_q[$];
  logic [64:0] exp8_q[$];
  logic [64:0] e32, e8, last32;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(st32), .op(op32), .src_a(a32), .src_b(b32),
    .cancel(cn32), .busy(busy32), .done(done32), .hi_out(hi32), .lo_out(lo32),
    .div_zero(dz32), .dbg_state(state32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .op(op8), .src_a(a8), .src_b(b8),
    .cancel(cn8), .busy(busy8), .done(done8), .hi_out(hi8), .lo_out(lo8),
    .div_zero(dz8), .dbg_state(state8)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: native 64-bit arithmetic, packed as {div_zero, hi, lo}.
  function automatic logic [64:0] model(input int w, input logic [1:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ua, ub, p, r64;
    longint      sa, sb;
    logic [31:0] hi, lo;
    logic        dz;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = longint'(ua);
    sb   = longint'(ub);
    if (ua[w-1]) sa = sa - (longint'(1) << w);
    if (ub[w-1]) sb = sb - (longint'(1) << w);
    dz = 1'b0;
    p  = 64'd0;
    case (op)
      2'b00: p = 64'(sa * sb);
      2'b01: p = ua * ub;
      default: begin
        if (ub == 64'd0) begin
          dz = 1'b1;
          p  = (ua << w) | mask;
        end else if (op == 2'b10) begin
          p = ((64'(sa % sb) & mask) << w) | (64'(sa / sb) & mask);
        end else begin
          p = (((ua % ub) & mask) << w) | ((ua / ub) & mask);
        end
      end
    endcase
    r64 = p & mask;
    lo  = r64[31:0];
    r64 = (p >> w) & mask;
    hi  = r64[31:0];
    return {dz, hi, lo};
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      chk("done32_expected", 65'(exp32_q.size() != 0), 65'd1);
      if (exp32_q.size() != 0) begin
        e32 = exp32_q.pop_front();
        chk("result32", {dz32, hi32, lo32}, e32);
        last32 = e32;
      end
    end
    if (done8 === 1'b1) begin
      chk("done8_expected", 65'(exp8_q.size() != 0), 65'd1);
      if (exp8_q.size() != 0) begin
        e8 = exp8_q.pop_front();
        chk("result8", {dz8, 24'd0, hi8, 24'd0, lo8}, e8);
      end
    end
  end

  // Drives one op, checks busy and latency; returns in the cycle done is seen.
  // imm=1 drives start in the current cycle; ign_at>0 pulses a stray start at edge k+ign_at.
  task automatic run_op(input bit w8, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input bit imm,
                        input int ign_at);
    int n;
    if (!imm) @(negedge clk);
    if (w8) begin
      st8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      exp8_q.push_back(model(8, op, a, b));
    end else begin
      st32 = 1'b1; op32 = op; a32 = a; b32 = b;
      exp32_q.push_back(model(32, op, a, b));
    end
    @(negedge clk);
    st8 = 1'b0; st32 = 1'b0;
    chk(w8 ? "busy8_after_accept" : "busy32_after_accept", 65'(w8 ? busy8 : busy32), 65'd1);
    n = 0;
    while (((w8 ? done8 : done32) !== 1'b1) && n < 200) begin
      if (ign_at > 0 && n == ign_at - 1) begin
        if (w8) begin st8 = 1'b1; op8 = ~op; a8 = ~a8; b8 = b8 + 8'd1; end
        else begin st32 = 1'b1; op32 = ~op; a32 = ~a32; b32 = b32 + 32'd1; end
      end
      @(negedge clk);
      st8 = 1'b0; st32 = 1'b0;
      n++;
    end
    chk(w8 ? "latency8" : "latency32", 65'(n), 65'(exp_lat));
    chk(w8 ? "busy8_at_done" : "busy32_at_done", 65'(w8 ? busy8 : busy32), 65'd0);
  endtask

  initial begin
    rst = 1'b1;
    st32 = 1'b1; op32 = 2'b01; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF; cn32 = 1'b0;
    st8  = 1'b1; op8  = 2'b00; a8  = 8'h80;        b8  = 8'h80;        cn8  = 1'b0;
    last32 = '0;

    // Reset held with start asserted: everything stays zero.
    repeat (2) begin
      @(negedge clk);
      chk("rst32_result", {dz32, hi32, lo32}, 65'd0);
      chk("rst32_busy_done", 65'({busy32, done32}), 65'd0);
      chk("rst8_result", {dz8, 24'd0, hi8, 24'd0, lo8}, 65'd0);
      chk("rst8_busy_done", 65'({busy8, done8}), 65'd0);
    end
    rst = 1'b0; st32 = 1'b0; st8 = 1'b0;

    run_op(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 0, 0);
    run_op(0, 2'b00, 32'hFFFFFFF9, 32'd3,        35, 0, 5);   // stray start ignored
    run_op(0, 2'b10, 32'hFFFFFFF9, 32'd2,        35, 1, 0);   // back-to-back accept
    run_op(0, 2'b10, 32'd7,        32'hFFFFFFFE, 35, 0, 0);
    run_op(0, 2'b11, 32'h80000000, 32'd3,        35, 0, 0);
    run_op(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 35, 0, 0);
    run_op(0, 2'b11, 32'd5,        32'd0,        2,  0, 0);
    run_op(0, 2'b01, 32'd6,        32'd7,        35, 0, 0);   // clears div_zero
    run_op(0, 2'b10, 32'hFFFFFFFF, 32'd0,        2,  0, 0);
    run_op(0, 2'b00, 32'd123456,   32'hFFFFFCEB, 35, 0, 0);

    // Cancel sampled at edge k+10 of a MULT: no done, outputs keep last result.
    @(negedge clk);
    st32 = 1'b1; op32 = 2'b00; a32 = 32'd1000; b32 = 32'd2000;
    @(negedge clk);
    st32 = 1'b0;
    repeat (9) @(negedge clk);
    cn32 = 1'b1;
    @(negedge clk);
    cn32 = 1'b0;
    chk("cancel32_busy", 65'(busy32), 65'd0);
    chk("cancel32_state", 65'(state32), 65'd0);
    repeat (40) @(negedge clk);
    chk("cancel32_hold", {dz32, hi32, lo32}, last32);
    run_op(0, 2'b11, 32'd1000, 32'd7, 35, 0, 0);

    // 8-bit instance: directed corners then randomized ops.
    run_op(1, 2'b00, 32'h80, 32'h80, 11, 0, 0);
    run_op(1, 2'b10, 32'h81, 32'h03, 11, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] rop;
      logic [7:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0:       rb = 8'h00;
        1:       rb = 8'h80;
        2:       rb = 8'hFF;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 9) == 0) ra = 8'h80;
      run_op(1, rop, {24'd0, ra}, {24'd0, rb}, (rop[1] && rb == 8'd0) ? 2 : 11,
             1'($urandom_range(0, 1)), 0);
    end

    // Reset mid-operation wins over the op in flight.
    @(negedge clk);
    st32 = 1'b1; op32 = 2'b01; a32 = 32'd77; b32 = 32'd99;
    @(negedge clk);
    st32 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst32_result", {dz32, hi32, lo32}, 65'd0);
    chk("midrst32_busy", 65'(busy32), 65'd0);
    repeat (40) @(negedge clk);
    run_op(0, 2'b01, 32'd77, 32'd99, 35, 0, 0);

    repeat (3) @(negedge clk);
    chk("queue32_drained", 65'(exp32_q.size()), 65'd0);
    chk("queue8_drained", 65'(exp8_q.size()), 65'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
